// File: rtl/dct_pkg.sv
// dct_pkg: constants and types shared by the DCT cosine sequencer and the
// DCT MAC controller.
//   DCT_ROM_AW / DCT_ROM_DW : address and data width of the DCT_COS ROM
//   DCT_ROM_AMP             : ROM amplitude, entry a = round(AMP*cos(2*pi*a/512))
//   dct_state_e             : IDLE / RUN / DONE control states
//   dct_scale()             : address stride S = 512/(4N) for a given log2(N)
package dct_pkg;

  localparam int DCT_ROM_AW  = 9;
  localparam int DCT_ROM_DW  = 9;
  localparam int DCT_ROM_AMP = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dct_state_e;

  // One ROM period covers 512 entries, and the DCT-II phase step is pi/(2N),
  // so one unit of k*(2n+1) is 512/(4N) = 2^(7-log2 N) entries.
  function automatic logic [DCT_ROM_AW-1:0] dct_scale(input int n_log2);
    return DCT_ROM_AW'(1) << (7 - n_log2);
  endfunction

endpackage

// File: rtl/dct_cos_seq_if.sv
// dct_cos_seq_if: coefficient stream from the cosine sequencer to the DCT MAC.
//   coef_valid / coef_ready : handshake, beat transfers when both are high
//   coef_data               : signed cosine sample
//   coef_k / coef_n         : DCT output / input index of the beat
//   coef_last_n             : beat closes a row (n = N-1)
//   coef_last               : final beat of the transform
// master = sequencer side, slave = MAC side.
interface dct_cos_seq_if #(
  parameter int N_LOG2 = 5,
  parameter int ROM_DW = 9
);

  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [ROM_DW-1:0] coef_data;
  logic [N_LOG2-1:0]        coef_k;
  logic [N_LOG2-1:0]        coef_n;
  logic                     coef_last_n;
  logic                     coef_last;

  modport master (
    output coef_valid, coef_data, coef_k, coef_n, coef_last_n, coef_last,
    input  coef_ready
  );

  modport slave (
    input  coef_valid, coef_data, coef_k, coef_n, coef_last_n, coef_last,
    output coef_ready
  );

endinterface

// File: rtl/dct_cos_addr_gen.sv
// dct_cos_addr_gen: fetch stage of the cosine sequencer. Holds the (k, n)
// counters and produces ROM address (k*(2n+1)*S) mod 512 incrementally.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : restart at (0,0), address 0
//   adv               : move to the next (k, n) pair
//   k_num             : number of rows K (already normalised to 1..N)
//   k_p0, n_p0        : indices of the pair currently addressed
//   rom_addr          : registered ROM address for (k_p0, n_p0)
//   last_n_p0, last_p0: pair is at n = N-1 / at (K-1, N-1)
module dct_cos_addr_gen
  import dct_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int ROM_AW = DCT_ROM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [N_LOG2:0]   k_num,
  output logic [N_LOG2-1:0] k_p0,
  output logic [N_LOG2-1:0] n_p0,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              last_n_p0,
  output logic              last_p0
);

  localparam logic [ROM_AW-1:0] S     = ROM_AW'(dct_scale(N_LOG2));
  localparam logic [ROM_AW-1:0] S2    = S << 1;
  localparam logic [N_LOG2-1:0] N_MAX = '1;

  // base = k*S, step = 2k*S; both wrap mod 512 along with the address,
  // so no multiplier is needed.
  logic [ROM_AW-1:0] base;
  logic [ROM_AW-1:0] step;

  assign last_n_p0 = (n_p0 == N_MAX);
  assign last_p0   = last_n_p0 && ({1'b0, k_p0} == (k_num - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_p0     <= '0;
      n_p0     <= '0;
      base     <= '0;
      step     <= '0;
      rom_addr <= '0;
    end else if (clr) begin
      k_p0     <= '0;
      n_p0     <= '0;
      base     <= '0;
      step     <= '0;
      rom_addr <= '0;
    end else if (adv) begin
      if (last_n_p0) begin
        k_p0     <= k_p0 + 1'b1;
        n_p0     <= '0;
        base     <= base + S;
        step     <= step + S2;
        rom_addr <= base + S;
      end else begin
        n_p0     <= n_p0 + 1'b1;
        rom_addr <= rom_addr + step;
      end
    end
  end

endmodule

// File: rtl/dct_cos_seq.sv
// dct_cos_seq: walks every (k, n) pair of an N-point DCT-II, addresses the
// external combinational cosine ROM and streams coefficients to the MAC.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a transform (ignored while busy)
//   cfg_k_num  : rows K, sampled with start; 0 or > N means N
//   busy, done : transform in progress / one-cycle completion pulse
//   rom_addr   : registered ROM address; rom_data : ROM output, same cycle
//   coef       : coefficient stream (master side)
module dct_cos_seq
  import dct_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int ROM_AW = DCT_ROM_AW,
  parameter int ROM_DW = DCT_ROM_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_LOG2:0]          cfg_k_num,
  output logic                     busy,
  output logic                     done,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic signed [ROM_DW-1:0] rom_data,
  dct_cos_seq_if.master            coef
);

  localparam int              N_INT = 1 << N_LOG2;
  localparam logic [N_LOG2:0] N_VAL = N_INT[N_LOG2:0];

  dct_state_e        state, state_nxt;
  logic [N_LOG2:0]   k_num;
  logic              vld_p0;
  logic [N_LOG2-1:0] k_p0, n_p0;
  logic              last_n_p0, last_p0;
  logic              accept, adv, fetch_adv, fire;

  assign accept    = (state == IDLE) && start;
  // Output register may load when empty or when its beat is being taken.
  assign adv       = !coef.coef_valid || coef.coef_ready;
  assign fetch_adv = (state == RUN) && vld_p0 && adv;
  assign fire      = coef.coef_valid && coef.coef_ready && coef.coef_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (fire) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_num  <= '0;
      vld_p0 <= 1'b0;
    end else if (accept) begin
      k_num  <= ((cfg_k_num == '0) || (cfg_k_num > N_VAL)) ? N_VAL : cfg_k_num;
      vld_p0 <= 1'b1;
    end else if (fetch_adv && last_p0) begin
      vld_p0 <= 1'b0;
    end
  end

  // Stage p0: fetch (k, n, rom_addr)
  dct_cos_addr_gen #(
    .N_LOG2 (N_LOG2),
    .ROM_AW (ROM_AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .adv       (fetch_adv),
    .k_num     (k_num),
    .k_p0      (k_p0),
    .n_p0      (n_p0),
    .rom_addr  (rom_addr),
    .last_n_p0 (last_n_p0),
    .last_p0   (last_p0)
  );

  // Stage p1: output register, loads the ROM sample for the fetched pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef.coef_valid  <= 1'b0;
      coef.coef_data   <= '0;
      coef.coef_k      <= '0;
      coef.coef_n      <= '0;
      coef.coef_last_n <= 1'b0;
      coef.coef_last   <= 1'b0;
    end else if ((state == RUN) && adv) begin
      coef.coef_valid <= vld_p0;
      if (vld_p0) begin
        coef.coef_data   <= rom_data;
        coef.coef_k      <= k_p0;
        coef.coef_n      <= n_p0;
        coef.coef_last_n <= last_n_p0;
        coef.coef_last   <= last_p0;
      end
    end
  end

endmodule

// File: tb/tb_dct_cos_seq.sv
`timescale 1ns/1ps
module tb_dct_cos_seq;
  import dct_pkg::*;

  localparam int NL  = 5;
  localparam int NL2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start0, start1;
  logic [NL:0]       cfg0;
  logic [NL2:0]      cfg1;
  logic              busy0, done0, busy1, done1;
  logic [8:0]        addr0, addr1;
  logic signed [8:0] rdata0, rdata1;
  int                rom [512];

  dct_cos_seq_if #(.N_LOG2(NL),  .ROM_DW(9)) cif0 ();
  dct_cos_seq_if #(.N_LOG2(NL2), .ROM_DW(9)) cif1 ();

  assign rdata0 = 9'(rom[addr0]);
  assign rdata1 = 9'(rom[addr1]);

  dct_cos_seq #(.N_LOG2(NL)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_k_num(cfg0),
    .busy(busy0), .done(done0), .rom_addr(addr0), .rom_data(rdata0),
    .coef(cif0)
  );

  dct_cos_seq #(.N_LOG2(NL2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_k_num(cfg1),
    .busy(busy1), .done(done1), .rom_addr(addr1), .rom_data(rdata1),
    .coef(cif1)
  );

  typedef struct {
    int k; int n; int addr; int data; bit ln; bit l;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  logic [8:0]  disp_addr [2];
  bit          prev_stall [2];
  logic [25:0] snap [2];
  int          beats [2];
  int          first_hs [2];
  int          last_hs [2];
  int          done_cnt [2];
  bit          done_due [2];
  bit          idle_due [2];
  int          last_beat_addr [2];
  int          start_cyc, done_cyc, lat_a;
  int          alog[$];
  int          nlog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected beats from the closed-form address k*(2n+1)*S mod 512.
  task automatic push_run(input int sel, input int nlog2, input int kk);
    int nn;
    int s;
    exp_t e;
    nn = 1 << nlog2;
    s  = 512 / (4 * nn);
    for (int k = 0; k < kk; k++) begin
      for (int n = 0; n < nn; n++) begin
        e.k    = k;
        e.n    = n;
        e.addr = (k * (2 * n + 1) * s) % 512;
        e.data = rom[e.addr];
        e.ln   = (n == nn - 1);
        e.l    = (n == nn - 1) && (k == kk - 1);
        if (sel == 0) sb0.push_back(e);
        else          sb1.push_back(e);
      end
    end
  endtask

  task automatic mon(input int sel);
    logic v, r, ln, l, dn, bz;
    logic [6:0] k, n;
    logic signed [8:0] d;
    logic [8:0] ra;
    logic [25:0] cur;
    exp_t e;
    int sz;
    if (sel == 0) begin
      v = cif0.coef_valid; r = cif0.coef_ready; d = cif0.coef_data;
      k = 7'(cif0.coef_k); n = 7'(cif0.coef_n);
      ln = cif0.coef_last_n; l = cif0.coef_last;
      dn = done0; bz = busy0; ra = addr0;
    end else begin
      v = cif1.coef_valid; r = cif1.coef_ready; d = cif1.coef_data;
      k = 7'(cif1.coef_k); n = 7'(cif1.coef_n);
      ln = cif1.coef_last_n; l = cif1.coef_last;
      dn = done1; bz = busy1; ra = addr1;
    end
    cur = {v, d, k, n, ln, l};
    if (prev_stall[sel]) check($sformatf("hold_stable%0d", sel), 64'(cur), 64'(snap[sel]));
    if (done_due[sel]) begin
      check($sformatf("done_pulse%0d", sel), 64'(dn), 64'(1));
      done_due[sel] = 1'b0;
      idle_due[sel] = 1'b1;
    end else if (idle_due[sel]) begin
      check($sformatf("busy_after_done%0d", sel), 64'(bz), 64'(0));
      idle_due[sel] = 1'b0;
    end
    if (dn) done_cnt[sel]++;
    if (v && r) begin
      sz = (sel == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
        check($sformatf("sb_underflow%0d", sel), 64'(sz), 64'(1));
      end else begin
        e = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("beat_kn%0d", sel), {50'd0, k, n}, {50'd0, 7'(e.k), 7'(e.n)});
        check($sformatf("beat_addr%0d", sel), 64'(disp_addr[sel]), 64'(e.addr));
        check($sformatf("beat_data%0d", sel), 64'(d), 64'(e.data));
        check($sformatf("beat_flags%0d", sel), {62'd0, ln, l}, {62'd0, e.ln, e.l});
      end
      beats[sel]++;
      if (beats[sel] == 1) first_hs[sel] = cyc_cnt;
      last_hs[sel] = cyc_cnt;
      if (sel == 1) begin
        alog.push_back(int'(disp_addr[1]));
        nlog.push_back(int'(ln));
      end
      if (l) begin
        done_due[sel]       = 1'b1;
        last_beat_addr[sel] = int'(disp_addr[sel]);
      end
    end
    prev_stall[sel] = v && !r;
    snap[sel]       = cur;
    // The beat shown after the next edge is loaded from the current address.
    if (!v || r) disp_addr[sel] = ra;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon(0);
    mon(1);
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sel, input int kcfg, input int kexp);
    push_run(sel, (sel == 0) ? NL : NL2, kexp);
    beats[sel]    = 0;
    done_cnt[sel] = 0;
    start_cyc     = cyc_cnt;
    if (sel == 0) begin start0 = 1'b1; cfg0 = 6'(kcfg); end
    else          begin start1 = 1'b1; cfg1 = 2'(kcfg); end
    cyc();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run_to_done(input int sel, input int budget, input bit rnd);
    int c;
    logic dn;
    c  = 0;
    dn = 1'b0;
    while (c < budget && !dn) begin
      if (rnd) cif0.coef_ready = 1'($urandom_range(0, 1));
      cyc();
      c++;
      dn = (sel == 0) ? done0 : done1;
    end
    done_cyc = cyc_cnt;
    cif0.coef_ready = 1'b1;
    check($sformatf("run_reaches_done%0d", sel), 64'(dn), 64'(1));
    cyc();
    cyc();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl0"}, {61'd0, busy0, done0, cif0.coef_valid}, 64'd0);
    check({tag, "_addr0"}, 64'(addr0), 64'd0);
    check({tag, "_coef0"},
          {40'd0, cif0.coef_data, cif0.coef_k, cif0.coef_n, cif0.coef_last_n, cif0.coef_last},
          64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a [4];
    int exp_ln [4];
    exp_a  = '{0, 0, 64, 192};
    exp_ln = '{0, 1, 0, 1};
    for (int a = 0; a < 512; a++)
      rom[a] = $rtoi($floor(real'(DCT_ROM_AMP) * $cos(2.0 * 3.14159265358979 * a / 512.0) + 0.5));
    for (int i = 0; i < 2; i++) begin
      disp_addr[i] = '0; prev_stall[i] = 0; snap[i] = '0; beats[i] = 0;
      first_hs[i] = 0; last_hs[i] = 0; done_cnt[i] = 0; done_due[i] = 0;
      idle_due[i] = 0; last_beat_addr[i] = 0;
    end
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; cfg0 = '0; cfg1 = '0;
    cif0.coef_ready = 1'b1;
    cif1.coef_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    check("reset_dut1", {54'd0, busy1, done1, cif1.coef_valid, addr1[6:0]}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // N=32, K=13, always ready
    do_start(0, 13, 13);
    check("start_busy", 64'(busy0), 64'd1);
    check("start_addr", 64'(addr0), 64'd0);
    check("start_valid_low", 64'(cif0.coef_valid), 64'd0);
    cyc();
    check("valid_after_2", 64'(cif0.coef_valid), 64'd1);
    run_to_done(0, 2000, 1'b0);
    lat_a = done_cyc - start_cyc;
    check("a_beats", 64'(beats[0]), 64'd416);
    check("a_no_gaps", 64'(last_hs[0] - first_hs[0] + 1), 64'd416);
    check("a_done_once", 64'(done_cnt[0]), 64'd1);
    check("a_sb_empty", 64'(sb0.size()), 64'd0);
    check("a_last_addr", 64'(last_beat_addr[0]), 64'd464);

    // K=0 behaves as K=N
    do_start(0, 0, 32);
    run_to_done(0, 3000, 1'b0);
    check("b_beats", 64'(beats[0]), 64'd1024);
    check("b_last_addr", 64'(last_beat_addr[0]), 64'd132);
    check("b_sb_empty", 64'(sb0.size()), 64'd0);

    // random backpressure
    do_start(0, 13, 13);
    run_to_done(0, 4000, 1'b1);
    check("c_beats", 64'(beats[0]), 64'd416);
    check("c_done_once", 64'(done_cnt[0]), 64'd1);
    check("c_sb_empty", 64'(sb0.size()), 64'd0);

    // start while busy is ignored
    do_start(0, 13, 13);
    repeat (50) cyc();
    start0 = 1'b1; cfg0 = 6'd5;
    cyc();
    start0 = 1'b0;
    run_to_done(0, 2000, 1'b0);
    check("d_beats", 64'(beats[0]), 64'd416);
    check("d_latency", 64'(done_cyc - start_cyc), 64'(lat_a));
    check("d_sb_empty", 64'(sb0.size()), 64'd0);

    // asynchronous reset mid-run, then a fresh transform
    do_start(0, 32, 32);
    for (int c = 0; c < 500 && beats[0] < 100; c++) cyc();
    check("e_reached_100", 64'(beats[0]), 64'd100);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    sb0.delete();
    prev_stall[0] = 0; done_due[0] = 0; idle_due[0] = 0; done_cnt[0] = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    check("e_no_done", 64'(done_cnt[0]), 64'd0);
    do_start(0, 32, 32);
    run_to_done(0, 3000, 1'b0);
    check("e_beats", 64'(beats[0]), 64'd1024);
    check("e_sb_empty", 64'(sb0.size()), 64'd0);

    // N=2, K=2
    alog.delete();
    nlog.delete();
    do_start(1, 2, 2);
    run_to_done(1, 50, 1'b0);
    check("f_beats", 64'(beats[1]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < alog.size()) begin
        check($sformatf("f_addr%0d", i), 64'(alog[i]), 64'(exp_a[i]));
        check($sformatf("f_last_n%0d", i), 64'(nlog[i]), 64'(exp_ln[i]));
      end
    end
    check("f_sb_empty", 64'(sb1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
